// File: rtl/ram_sc_mc_pkg.sv
// Shared types and parameter limits for the multi-lane single-clock RAM.
// Forwarding option is selected with RAM_SC_MC_FORWARD_EN.
package ram_sc_mc_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CH_MIN     = 1;
    localparam int CH_MAX     = 8;

    function automatic bit params_ok(
        int ch,
        int lat,
        int ram_size,
        int word_size
    );
        return (ch >= CH_MIN) && (ch <= CH_MAX) &&
               (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX) &&
               (ram_size >= 2) && (word_size >= 1);
    endfunction

endpackage

// File: rtl/ram_sc_lane.sv
// One lane of storage with its output register.
// RAM_SC_MC_FORWARD_EN adds registered write-to-read forwarding.
module ram_sc_lane
    import ram_sc_mc_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int RAM_SIZE  = 1024,
    parameter int AW        = $clog2(RAM_SIZE)
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    output logic [WORD_SIZE-1:0] q
);

    logic [WORD_SIZE-1:0] mem [RAM_SIZE];
    logic [WORD_SIZE-1:0] mem_q;

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) mem_q <= mem[raddr];
    end

`ifdef RAM_SC_MC_FORWARD_EN
    logic                 fwd;
    logic [WORD_SIZE-1:0] wd_r;

    // Kept beside mem_q so the array itself stays a plain BRAM
    always_ff @(posedge clock) begin
        if (re) begin
            fwd  <= we && (waddr == raddr);
            wd_r <= wdata;
        end
    end

    assign q = fwd ? wd_r : mem_q;
`else
    assign q = mem_q;
`endif

endmodule

// File: rtl/ram_sc_mc.sv
// Multi-lane single-clock RAM with clear engine and pipelined reads.
// Define RAM_SC_MC_FORWARD_EN for same-address write forwarding.
module ram_sc_mc
    import ram_sc_mc_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int CHANNELS       = 3,
    parameter int RAM_SIZE       = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(RAM_SIZE),
    localparam int DW            = CHANNELS * WORD_SIZE
) (
    input  logic                clock,
    input  logic                n_rst,
    input  logic                clear,
    output logic                busy,
    input  logic [CHANNELS-1:0] wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic                rd_valid
);

    if (!params_ok(CHANNELS, RD_LATENCY, RAM_SIZE, WORD_SIZE)) begin : g_bad_params
        $error("ram_sc_mc: parameter out of range");
    end

    localparam logic [AW:0]   SIZE_W = (AW+1)'(RAM_SIZE);
    localparam logic [AW-1:0] LAST   = AW'(RAM_SIZE - 1);

    state_t          state, state_n;
    logic [AW-1:0]   clr_addr, clr_n;
    logic            wr_ok, rd_ok, acc;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   lane_q;
    logic            oob_r;
    logic [DW-1:0]   s0, dout;
    logic [RD_LATENCY-1:0] vld;

    assign busy  = (state == ST_CLEAR);
    assign wr_ok = {1'b0, wr_addr} < SIZE_W;
    assign rd_ok = {1'b0, rd_addr} < SIZE_W;
    assign acc   = rd_en && !busy;

    always_comb begin
        state_n = state;
        clr_n   = clr_addr;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_n = ST_CLEAR;
                    clr_n   = '0;
                end
            end
            ST_CLEAR: begin
                clr_n = clr_addr + AW'(1);
                if (clr_addr == LAST) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_n;
        end
    end

    assign mem_waddr = busy ? clr_addr : wr_addr;
    assign mem_wdata = busy ? '0 : wr_data;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        ram_sc_lane #(
            .WORD_SIZE (WORD_SIZE),
            .RAM_SIZE  (RAM_SIZE),
            .AW        (AW)
        ) u_lane (
            .clock (clock),
            .we    (busy || (wr_en[c] && wr_ok)),
            .waddr (mem_waddr),
            .wdata (mem_wdata[c*WORD_SIZE +: WORD_SIZE]),
            .re    (acc && rd_ok),
            .raddr (rd_addr),
            .q     (lane_q[c*WORD_SIZE +: WORD_SIZE])
        );
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            vld   <= '0;
            oob_r <= 1'b0;
        end else begin
            vld[0] <= acc;
            for (int i = 1; i < RD_LATENCY; i++) vld[i] <= vld[i-1];
            oob_r <= acc && !rd_ok;
        end
    end

    // Out-of-range reads never touch the lanes; zero them here
    assign s0 = oob_r ? '0 : lane_q;

    if (RD_LATENCY == 1) begin : g_lat1
        assign dout = s0;
    end else begin : g_latn
        logic [DW-1:0] dr [RD_LATENCY-1];

        always_ff @(posedge clock or negedge n_rst) begin
            if (!n_rst) begin
                for (int i = 0; i < RD_LATENCY-1; i++) dr[i] <= '0;
            end else begin
                dr[0] <= s0;
                for (int i = 1; i < RD_LATENCY-1; i++) dr[i] <= dr[i-1];
            end
        end

        assign dout = dr[RD_LATENCY-2];
    end

    assign rd_valid = vld[RD_LATENCY-1];
    assign rd_data  = rd_valid ? dout : '0;

endmodule

// File: tb/tb_ram_sc_mc.sv
// Randomized and directed bench for ram_sc_mc against an array model.
// Honours RAM_SC_MC_FORWARD_EN when computing collision results.
module tb_ram_sc_mc;

    localparam int W   = 8;
    localparam int CH  = 3;
    localparam int RS  = 12;
    localparam int LAT = 3;
    localparam int AW  = 4;
    localparam int DW  = CH * W;

    logic          clock = 1'b0;
    logic          n_rst = 1'b1;
    logic          clear = 1'b0;
    logic [CH-1:0] wr_en = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          busy;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    ram_sc_mc #(
        .WORD_SIZE      (W),
        .CHANNELS       (CH),
        .RAM_SIZE       (RS),
        .RD_LATENCY     (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .clear    (clear),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mdl [RS];
    int            busy_left = 0;
    bit            ev [8];
    logic [DW-1:0] ed [8];
    int            cyc = 0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, predict, check at the next negedge
    task automatic step(bit clr, logic [CH-1:0] we, int wa,
                        logic [DW-1:0] wd, bit re, int ra);
        logic [DW-1:0] r;
        bit            bnow;
        int            slot;
        clear   = clr;
        wr_en   = we;
        wr_addr = wa[AW-1:0];
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra[AW-1:0];
        bnow = busy_left > 0;
        if (re && !bnow) begin
            r = '0;
            if (ra < RS) begin
                r = mdl[ra];
`ifdef RAM_SC_MC_FORWARD_EN
                if (wa == ra)
                    for (int c = 0; c < CH; c++)
                        if (we[c]) r[c*W +: W] = wd[c*W +: W];
`endif
            end
            slot = (cyc + LAT) % 8;
            ev[slot] = 1'b1;
            ed[slot] = r;
        end
        if (!bnow && wa < RS)
            for (int c = 0; c < CH; c++)
                if (we[c]) mdl[wa][c*W +: W] = wd[c*W +: W];
        if (bnow) busy_left--;
        else if (clr) begin
            busy_left = RS;
            for (int i = 0; i < RS; i++) mdl[i] = '0;
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
        slot = cyc % 8;
        chk("busy", busy, busy_left > 0);
        chk("rd_valid", rd_valid, ev[slot]);
        chk("rd_data", rd_data, ev[slot] ? ed[slot] : '0);
        if (rd_valid) last_data = rd_data;
        ev[slot] = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 0, '0, 1'b0, 0);
    endtask

    task automatic rd(int a);
        step(1'b0, '0, 0, '0, 1'b1, a);
    endtask

    task automatic wr(int a, logic [DW-1:0] d, logic [CH-1:0] we);
        step(1'b0, we, a, d, 1'b0, 0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        clear = 1'b0;
        wr_en = '0;
        rd_en = 1'b0;
        #1;
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, '0);
        chk("rst_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) ev[i] = 1'b0;
        for (int i = 0; i < RS; i++) mdl[i] = '0;
        busy_left = RS;
        repeat (2) @(negedge clock);
        n_rst = 1'b1;
    endtask

    // Random traffic while busy; optional clear re-pulse mid-clear
    task automatic busy_run(bit repulse, output int n);
        n = 0;
        while (busy === 1'b1 && n < 4*RS) begin
            step(repulse && n == 4, CH'($urandom), $urandom_range(0, 15),
                 DW'($urandom), 1'b1, $urandom_range(0, 15));
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int wa;
        int ra;
        for (int i = 0; i < 8; i++) ev[i] = 1'b0;
        @(negedge clock);

        do_reset();
        busy_run(1'b0, n);
        chk("por_busy_len", n, RS);
        for (int a = 0; a < RS; a++) rd(a);
        repeat (LAT) idle();

        wr(5, 24'h332211, 3'b111);
        wr(5, 24'hAA5566, 3'b100);
        rd(5);
        repeat (LAT) idle();
        chk("lane_mask", last_data, 24'hAA2211);

        wr(1, 24'h111111, 3'b111);
        wr(2, 24'h222222, 3'b111);
        wr(3, 24'h333333, 3'b111);
        rd(1);
        rd(2);
        idle();
        rd(3);
        repeat (LAT) idle();
        chk("gap_last", last_data, 24'h333333);

        wr(7, 24'h010203, 3'b111);
        step(1'b0, 3'b111, 7, 24'h0A0B0C, 1'b1, 7);
        repeat (LAT) idle();
`ifdef RAM_SC_MC_FORWARD_EN
        chk("collide", last_data, 24'h0A0B0C);
`else
        chk("collide", last_data, 24'h010203);
`endif

        wr(13, 24'h123456, 3'b111);
        rd(13);
        rd(11);
        rd(15);
        repeat (LAT) idle();
        chk("oob_read", last_data, 24'h0);

        wr(2, 24'h5A5A5A, 3'b111);
        rd(2);
        step(1'b1, '0, 0, '0, 1'b1, 5);
        busy_run(1'b1, n);
        chk("clr_busy_len", n, RS);
        for (int a = 0; a < RS; a++) rd(a);
        repeat (LAT) idle();

        repeat (400) begin
            wa = $urandom_range(0, 15);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            step($urandom_range(0, 99) == 0, CH'($urandom), wa,
                 DW'($urandom), bit'($urandom_range(0, 1)), ra);
        end
        repeat (RS + LAT) idle();

        rd(1);
        rd(2);
        step(1'b1, '0, 0, '0, 1'b1, 3);
        chk("inflight_seen", rd_valid, 1'b1);
        do_reset();
        busy_run(1'b0, n);
        chk("rst_busy_len", n, RS);
        for (int a = 0; a < RS; a++) rd(a);
        repeat (LAT) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
